// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, ALUOp classes, default widths and the
// decoded control bundle carried from ID into EX.
package mips_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_W  = 5;

  localparam logic [5:0] R_FORMAT = 6'd0;
  localparam logic [5:0] LW       = 6'd35;
  localparam logic [5:0] SW       = 6'd43;
  localparam logic [5:0] BEQ      = 6'd4;
  localparam logic [5:0] BNE      = 6'd5;
  localparam logic [5:0] ADDI     = 6'd8;
  localparam logic [5:0] ANDI     = 6'd12;
  localparam logic [5:0] ORI      = 6'd13;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_RTYPE = 3'b010;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       memto_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       branch_ne;
    logic [2:0] alu_op;
  } ctrl_t;

  // RegDst/MemtoReg are don't-cares when nothing is written back; force them
  // low so SW/BEQ/BNE never leak X into EX. An invalid slot carries no control.
  function automatic ctrl_t sanitize_ctrl(input ctrl_t c, input logic valid);
    ctrl_t s;
    s           = c;
    s.reg_dst   = c.reg_dst & c.reg_write;
    s.memto_reg = c.memto_reg & c.reg_write;
    if (!valid) s = '0;
    return s;
  endfunction

endpackage

// File: rtl/id_ex_stage_hazard_unit.sv
// Load-use detector: an EX-stage load whose destination is read by the
// instruction in ID forces one bubble unless that instruction is being flushed.
module hazard_unit #(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] ex_write_reg,
  input  logic             ex_mem_read,
  input  logic             ex_valid,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             uses_rt,
  input  logic             flush,
  output logic             load_use,
  output logic             stall
);

  logic dst_nonzero;
  logic rs_match;
  logic rt_match;

  always_comb begin
    dst_nonzero = (ex_write_reg != '0);
    rs_match    = (ex_write_reg == id_rs);
    rt_match    = uses_rt & (ex_write_reg == id_rt);
    load_use    = ex_valid & ex_mem_read & dst_nonzero & id_valid &
                  (rs_match | rt_match);
    stall       = load_use & ~flush;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush and a
// saturating count of inserted load-use bubbles.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_W  = DEF_REG_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic              RegDst,
  input  logic              ALUSrc,
  input  logic              MemtoReg,
  input  logic              RegWrite,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              Branch,
  input  logic              BranchNE,
  input  logic [2:0]        ALUOp,
  input  logic [5:0]        funct,
  input  logic [REG_W-1:0]  rs,
  input  logic [REG_W-1:0]  rt,
  input  logic [REG_W-1:0]  rd,
  input  logic [DATA_W-1:0] read_data1,
  input  logic [DATA_W-1:0] read_data2,
  input  logic [DATA_W-1:0] sign_ext_imm,
  input  logic [DATA_W-1:0] pc_plus4,
  input  logic              flush,
  output logic              ex_valid,
  output logic              ex_RegDst,
  output logic              ex_ALUSrc,
  output logic              ex_MemtoReg,
  output logic              ex_RegWrite,
  output logic              ex_MemRead,
  output logic              ex_MemWrite,
  output logic              ex_Branch,
  output logic              ex_BranchNE,
  output logic [2:0]        ex_ALUOp,
  output logic [5:0]        ex_funct,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_rd,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc_plus4,
  output logic [REG_W-1:0]  ex_write_reg,
  output logic              stall,
  output logic [CNT_W-1:0]  hazard_count
);

  ctrl_t             id_ctrl;
  ctrl_t             cap_ctrl;
  logic              uses_rt;
  logic              load_use;

  ctrl_t             ctrl_q,  ctrl_d;
  logic              valid_q, valid_d;
  logic [5:0]        funct_q, funct_d;
  logic [REG_W-1:0]  rs_q,    rs_d;
  logic [REG_W-1:0]  rt_q,    rt_d;
  logic [REG_W-1:0]  rd_q,    rd_d;
  logic [REG_W-1:0]  wr_q,    wr_d;
  logic [DATA_W-1:0] rd1_q,   rd1_d;
  logic [DATA_W-1:0] rd2_q,   rd2_d;
  logic [DATA_W-1:0] imm_q,   imm_d;
  logic [DATA_W-1:0] pc_q,    pc_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;

  // R-format, SW, BEQ and BNE read rt as a source; I-type ALU ops write it.
  assign uses_rt = ~ALUSrc | MemWrite;

  hazard_unit #(
    .REG_W (REG_W)
  ) u_hazard (
    .ex_write_reg (wr_q),
    .ex_mem_read  (ctrl_q.mem_read),
    .ex_valid     (valid_q),
    .id_valid     (id_valid),
    .id_rs        (rs),
    .id_rt        (rt),
    .uses_rt      (uses_rt),
    .flush        (flush),
    .load_use     (load_use),
    .stall        (stall)
  );

  always_comb begin
    id_ctrl = '{reg_dst:   RegDst,   alu_src:   ALUSrc,
                memto_reg: MemtoReg, reg_write: RegWrite,
                mem_read:  MemRead,  mem_write: MemWrite,
                branch:    Branch,   branch_ne: BranchNE,
                alu_op:    ALUOp};
    cap_ctrl = sanitize_ctrl(id_ctrl, id_valid);

    ctrl_d  = ctrl_q;
    valid_d = valid_q;
    funct_d = funct_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    imm_d   = imm_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;

    // A bubble clears only control; data fields keep their last values.
    if (flush || load_use) begin
      ctrl_d  = '0;
      valid_d = 1'b0;
    end else begin
      ctrl_d  = cap_ctrl;
      valid_d = id_valid;
      funct_d = funct;
      rs_d    = rs;
      rt_d    = rt;
      rd_d    = rd;
      wr_d    = cap_ctrl.reg_dst ? rd : rt;
      rd1_d   = read_data1;
      rd2_d   = read_data2;
      imm_d   = sign_ext_imm;
      pc_d    = pc_plus4;
    end

    if (stall && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q  <= '0;
      valid_q <= 1'b0;
      funct_q <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      funct_q <= funct_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      imm_q   <= imm_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ex_valid     = valid_q;
  assign ex_RegDst    = ctrl_q.reg_dst;
  assign ex_ALUSrc    = ctrl_q.alu_src;
  assign ex_MemtoReg  = ctrl_q.memto_reg;
  assign ex_RegWrite  = ctrl_q.reg_write;
  assign ex_MemRead   = ctrl_q.mem_read;
  assign ex_MemWrite  = ctrl_q.mem_write;
  assign ex_Branch    = ctrl_q.branch;
  assign ex_BranchNE  = ctrl_q.branch_ne;
  assign ex_ALUOp     = ctrl_q.alu_op;
  assign ex_funct     = funct_q;
  assign ex_rs        = rs_q;
  assign ex_rt        = rt_q;
  assign ex_rd        = rd_q;
  assign ex_rd1       = rd1_q;
  assign ex_rd2       = rd2_q;
  assign ex_imm       = imm_q;
  assign ex_pc_plus4  = pc_q;
  assign ex_write_reg = wr_q;
  assign hazard_count = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus random instruction streams
// checked against an instruction-level model of the ID->EX handoff.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic        reg_dst, alu_src, memto_reg, reg_write;
    logic        mem_read, mem_write, branch, branch_ne;
    logic [2:0]  alu_op;
    logic [5:0]  funct;
    logic [4:0]  rs, rt, rd, wr;
    logic [31:0] rd1, rd2, imm, pc;
  } ex_t;

  typedef struct packed {
    logic        valid;
    logic        reg_dst, alu_src, memto_reg, reg_write;
    logic        mem_read, mem_write, branch, branch_ne;
    logic [2:0]  alu_op;
    logic [5:0]  funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rd1, rd2, imm, pc;
    logic        flush;
  } id_t;

  localparam int K_R = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_BNE = 4, K_ADDI = 5, K_NONE = 6;

  logic clk = 1'b0;
  logic reset = 1'b0;
  id_t  id = '0;

  logic        ex_valid, ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite;
  logic        ex_MemRead, ex_MemWrite, ex_Branch, ex_BranchNE;
  logic [2:0]  ex_ALUOp;
  logic [5:0]  ex_funct;
  logic [4:0]  ex_rs, ex_rt, ex_rd, ex_write_reg;
  logic [31:0] ex_rd1, ex_rd2, ex_imm, ex_pc_plus4;
  logic        stall;
  logic [15:0] hazard_count;

  logic        s_valid, s_RegDst, s_ALUSrc, s_MemtoReg, s_RegWrite;
  logic        s_MemRead, s_MemWrite, s_Branch, s_BranchNE;
  logic [2:0]  s_ALUOp;
  logic [5:0]  s_funct;
  logic [4:0]  s_rs, s_rt, s_rd, s_write_reg;
  logic [31:0] s_rd1, s_rd2, s_imm, s_pc_plus4;
  logic        s_stall;
  logic [4:0]  s_count;

  ex_t dut_ex, small_ex;
  assign dut_ex = {ex_valid, ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite,
                   ex_MemRead, ex_MemWrite, ex_Branch, ex_BranchNE, ex_ALUOp,
                   ex_funct, ex_rs, ex_rt, ex_rd, ex_write_reg,
                   ex_rd1, ex_rd2, ex_imm, ex_pc_plus4};
  assign small_ex = {s_valid, s_RegDst, s_ALUSrc, s_MemtoReg, s_RegWrite,
                     s_MemRead, s_MemWrite, s_Branch, s_BranchNE, s_ALUOp,
                     s_funct, s_rs, s_rt, s_rd, s_write_reg,
                     s_rd1, s_rd2, s_imm, s_pc_plus4};

  id_ex_stage dut (
    .clk(clk), .reset(reset), .id_valid(id.valid),
    .RegDst(id.reg_dst), .ALUSrc(id.alu_src), .MemtoReg(id.memto_reg),
    .RegWrite(id.reg_write), .MemRead(id.mem_read), .MemWrite(id.mem_write),
    .Branch(id.branch), .BranchNE(id.branch_ne), .ALUOp(id.alu_op),
    .funct(id.funct), .rs(id.rs), .rt(id.rt), .rd(id.rd),
    .read_data1(id.rd1), .read_data2(id.rd2), .sign_ext_imm(id.imm),
    .pc_plus4(id.pc), .flush(id.flush),
    .ex_valid(ex_valid), .ex_RegDst(ex_RegDst), .ex_ALUSrc(ex_ALUSrc),
    .ex_MemtoReg(ex_MemtoReg), .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead),
    .ex_MemWrite(ex_MemWrite), .ex_Branch(ex_Branch), .ex_BranchNE(ex_BranchNE),
    .ex_ALUOp(ex_ALUOp), .ex_funct(ex_funct), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_rd(ex_rd), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
    .ex_pc_plus4(ex_pc_plus4), .ex_write_reg(ex_write_reg), .stall(stall),
    .hazard_count(hazard_count)
  );

  // Narrow-counter copy so saturation is reachable in a short run.
  id_ex_stage #(.CNT_W(5)) dut_small (
    .clk(clk), .reset(reset), .id_valid(id.valid),
    .RegDst(id.reg_dst), .ALUSrc(id.alu_src), .MemtoReg(id.memto_reg),
    .RegWrite(id.reg_write), .MemRead(id.mem_read), .MemWrite(id.mem_write),
    .Branch(id.branch), .BranchNE(id.branch_ne), .ALUOp(id.alu_op),
    .funct(id.funct), .rs(id.rs), .rt(id.rt), .rd(id.rd),
    .read_data1(id.rd1), .read_data2(id.rd2), .sign_ext_imm(id.imm),
    .pc_plus4(id.pc), .flush(id.flush),
    .ex_valid(s_valid), .ex_RegDst(s_RegDst), .ex_ALUSrc(s_ALUSrc),
    .ex_MemtoReg(s_MemtoReg), .ex_RegWrite(s_RegWrite), .ex_MemRead(s_MemRead),
    .ex_MemWrite(s_MemWrite), .ex_Branch(s_Branch), .ex_BranchNE(s_BranchNE),
    .ex_ALUOp(s_ALUOp), .ex_funct(s_funct), .ex_rs(s_rs), .ex_rt(s_rt),
    .ex_rd(s_rd), .ex_rd1(s_rd1), .ex_rd2(s_rd2), .ex_imm(s_imm),
    .ex_pc_plus4(s_pc_plus4), .ex_write_reg(s_write_reg), .stall(s_stall),
    .hazard_count(s_count)
  );

  always #5 clk = ~clk;

  int  checks = 0;
  int  failures = 0;
  ex_t exp = '0;
  int  exp_cnt = 0;

  // Instruction-level model: a load in EX whose nonzero destination is read
  // by the ID instruction costs one bubble; a flush kills ID outright.
  function automatic ex_t model_next(input ex_t cur, input id_t d, output bit st);
    ex_t n;
    bit  reads_rt, hz;
    n = cur;
    reads_rt = !d.alu_src || d.mem_write;
    hz = cur.valid && cur.mem_read && (cur.wr != 0) && d.valid &&
         ((cur.wr == d.rs) || (reads_rt && (cur.wr == d.rt)));
    st = hz && !d.flush;
    if (d.flush || hz) begin
      n.valid = 0; n.reg_dst = 0; n.alu_src = 0; n.memto_reg = 0; n.reg_write = 0;
      n.mem_read = 0; n.mem_write = 0; n.branch = 0; n.branch_ne = 0; n.alu_op = 0;
    end else begin
      n.valid = d.valid;
      if (d.valid) begin
        n.reg_write = d.reg_write;
        n.reg_dst   = d.reg_write ? d.reg_dst : 1'b0;
        n.memto_reg = d.reg_write ? d.memto_reg : 1'b0;
        n.alu_src = d.alu_src; n.mem_read = d.mem_read; n.mem_write = d.mem_write;
        n.branch = d.branch; n.branch_ne = d.branch_ne; n.alu_op = d.alu_op;
      end else begin
        n.reg_write = 0; n.reg_dst = 0; n.memto_reg = 0; n.alu_src = 0; n.mem_read = 0;
        n.mem_write = 0; n.branch = 0; n.branch_ne = 0; n.alu_op = 0;
      end
      n.funct = d.funct; n.rs = d.rs; n.rt = d.rt; n.rd = d.rd;
      n.wr  = n.reg_dst ? d.rd : d.rt;
      n.rd1 = d.rd1; n.rd2 = d.rd2; n.imm = d.imm; n.pc = d.pc;
    end
    return n;
  endfunction

  function automatic int sat31(input int v);
    return (v > 31) ? 31 : v;
  endfunction

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 3))
      0:       return 5'd0;
      1:       return 5'd8;
      2:       return 5'd9;
      default: return 5'($urandom);
    endcase
  endfunction

  task automatic load_instr(input int kind, input logic [4:0] rs_i, rt_i, rd_i);
    id = '0;
    id.valid = 1; id.rs = rs_i; id.rt = rt_i; id.rd = rd_i;
    id.funct = 6'($urandom); id.rd1 = $urandom; id.rd2 = $urandom;
    id.imm = $urandom; id.pc = $urandom;
    case (kind)
      K_R:    begin id.reg_dst = 1; id.reg_write = 1; id.alu_op = 3'b010; end
      K_LW:   begin id.alu_src = 1; id.memto_reg = 1; id.reg_write = 1; id.mem_read = 1; end
      K_SW:   begin id.alu_src = 1; id.mem_write = 1;
                    id.reg_dst = 1'($urandom); id.memto_reg = 1'($urandom); end
      K_BEQ:  begin id.branch = 1; id.alu_op = 3'b001;
                    id.reg_dst = 1'($urandom); id.memto_reg = 1'($urandom); end
      K_BNE:  begin id.branch_ne = 1; id.alu_op = 3'b001; end
      K_ADDI: begin id.alu_src = 1; id.reg_write = 1; end
      default: begin
        id.valid = 0;
        {id.reg_dst, id.alu_src, id.memto_reg, id.reg_write, id.mem_read,
         id.mem_write, id.branch, id.branch_ne} = 8'($urandom);
        id.alu_op = 3'($urandom);
      end
    endcase
  endtask

  // One clock: sample stall before the edge, advance the model at the edge.
  task automatic tick(output logic obs_st, output bit exp_st);
    bit  s;
    ex_t n;
    #1;
    obs_st = stall;
    n = model_next(exp, id, s);
    exp_st = s;
    @(posedge clk);
    exp = n;
    if (s) exp_cnt++;
    #1;
  endtask

  task automatic model_reset();
    exp = '0;
    exp_cnt = 0;
  endtask

  task automatic test_reset();
    logic os; bit es;
    reset = 1;
    for (int c = 0; c < 3; c++) begin
      load_instr($urandom_range(0, 6), pick_reg(), pick_reg(), pick_reg());
      @(negedge clk);
      checks++;
      if (dut_ex !== '0 || hazard_count !== 16'd0 || stall !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold: ex=%h cnt=%h stall=%b required all zero", dut_ex, hazard_count, stall);
      end
    end
    #2 reset = 0;
    model_reset();
    load_instr(K_R, 5'd4, 5'd5, 5'd6);
    tick(os, es);
    checks++;
    if (dut_ex !== exp || ex_valid !== 1'b1 || ex_write_reg !== 5'd6) begin
      failures++;
      $display("FAIL reset_first_capture: ex=%h required %h", dut_ex, exp);
    end
  endtask

  task automatic test_rtype();
    logic os; bit es;
    load_instr(K_R, 5'd1, 5'd2, 5'd3);
    id.rd1 = 32'h11; id.rd2 = 32'h22;
    tick(os, es);
    checks++;
    if (os !== 1'b0) begin failures++; $display("FAIL rtype_stall: got %b required 0", os); end
    checks++;
    if (ex_write_reg !== 5'd3 || ex_rd1 !== 32'h11 || ex_rd2 !== 32'h22 ||
        ex_ALUOp !== 3'b010 || ex_valid !== 1'b1) begin
      failures++;
      $display("FAIL rtype_fields: wr=%0d rd1=%h rd2=%h aluop=%b v=%b required 3 11 22 010 1",
               ex_write_reg, ex_rd1, ex_rd2, ex_ALUOp, ex_valid);
    end
    checks++;
    if (dut_ex !== exp) begin failures++; $display("FAIL rtype_model: got %h required %h", dut_ex, exp); end
  endtask

  task automatic test_load_use();
    logic os; bit es;
    int   kinds [3] = '{K_R, K_SW, K_ADDI};
    logic want  [3] = '{1'b1, 1'b1, 1'b0};
    int   c0;
    logic [31:0] held_rd1;
    for (int k = 0; k < 3; k++) begin
      load_instr(K_LW, 5'd1, 5'd8, 5'd0);
      tick(os, es);
      held_rd1 = ex_rd1;
      c0 = exp_cnt;
      load_instr(kinds[k], (k == 0) ? 5'd8 : 5'd1, (k == 0) ? 5'd2 : 5'd8, 5'd3);
      tick(os, es);
      checks++;
      if (os !== want[k] || os !== es) begin
        failures++;
        $display("FAIL load_use_stall[%0d]: got %b required %b", k, os, want[k]);
      end
      checks++;
      if (want[k] && (ex_valid !== 1'b0 || ex_RegWrite !== 1'b0 || ex_MemRead !== 1'b0 ||
                      ex_rd1 !== held_rd1 || ex_write_reg !== 5'd8)) begin
        failures++;
        $display("FAIL load_use_bubble[%0d]: v=%b rw=%b mr=%b rd1=%h wr=%0d required 0 0 0 %h 8",
                 k, ex_valid, ex_RegWrite, ex_MemRead, ex_rd1, held_rd1, ex_write_reg);
      end
      checks++;
      if (hazard_count !== 16'(c0 + (want[k] ? 1 : 0))) begin
        failures++;
        $display("FAIL load_use_count[%0d]: got %0d required %0d", k, hazard_count, c0 + (want[k] ? 1 : 0));
      end
      tick(os, es);
      checks++;
      if (os !== 1'b0 || dut_ex !== exp || ex_valid !== 1'b1) begin
        failures++;
        $display("FAIL load_use_release[%0d]: stall=%b ex=%h required stall 0 ex %h", k, os, dut_ex, exp);
      end
    end
  endtask

  task automatic test_zero_reg();
    logic os; bit es;
    int   c0;
    load_instr(K_LW, 5'd1, 5'd0, 5'd0);
    tick(os, es);
    c0 = exp_cnt;
    load_instr(K_R, 5'd0, 5'd0, 5'd3);
    tick(os, es);
    checks++;
    if (os !== 1'b0 || hazard_count !== 16'(c0) || ex_valid !== 1'b1) begin
      failures++;
      $display("FAIL zero_reg: stall=%b cnt=%0d v=%b required 0 %0d 1", os, hazard_count, c0, ex_valid);
    end
  endtask

  task automatic test_flush_priority();
    logic os; bit es;
    int   c0;
    load_instr(K_LW, 5'd1, 5'd8, 5'd0);
    tick(os, es);
    c0 = exp_cnt;
    load_instr(K_BEQ, 5'd8, 5'd9, 5'd0);
    id.flush = 1;
    tick(os, es);
    checks++;
    if (os !== 1'b0) begin failures++; $display("FAIL flush_stall: got %b required 0", os); end
    checks++;
    if (ex_valid !== 1'b0 || ex_Branch !== 1'b0 || hazard_count !== 16'(c0) || dut_ex !== exp) begin
      failures++;
      $display("FAIL flush_bubble: v=%b br=%b cnt=%0d required 0 0 %0d", ex_valid, ex_Branch, hazard_count, c0);
    end
    load_instr(K_SW, 5'd2, 5'd9, 5'd0);
    id.reg_dst = 1'bx; id.memto_reg = 1'bx;
    tick(os, es);
    checks++;
    if (ex_RegDst !== 1'b0 || ex_MemtoReg !== 1'b0 || ex_MemWrite !== 1'b1 || ex_write_reg !== 5'd9) begin
      failures++;
      $display("FAIL sanitise_sw: regdst=%b memtoreg=%b mw=%b wr=%0d required 0 0 1 9",
               ex_RegDst, ex_MemtoReg, ex_MemWrite, ex_write_reg);
    end
  endtask

  task automatic test_random();
    logic os; bit es;
    int   bad = 0;
    for (int c = 0; c < 400; c++) begin
      load_instr($urandom_range(0, 6), pick_reg(), pick_reg(), pick_reg());
      id.flush = ($urandom_range(0, 9) == 0);
      tick(os, es);
      checks++;
      if (os !== es || dut_ex !== exp || hazard_count !== exp_cnt[15:0]) begin
        failures++;
        if (bad++ < 5)
          $display("FAIL random[%0d]: stall=%b/%b cnt=%0d/%0d ex=%h required %h",
                   c, os, es, hazard_count, exp_cnt, dut_ex, exp);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    logic os; bit es;
    load_instr(K_LW, 5'd1, 5'd8, 5'd0);
    tick(os, es);
    load_instr(K_R, 5'd8, 5'd2, 5'd3);
    #1;
    checks++;
    if (stall !== 1'b1) begin failures++; $display("FAIL mid_stall_pre: stall=%b required 1", stall); end
    reset = 1;
    #1;
    checks++;
    if (stall !== 1'b0 || dut_ex !== '0 || hazard_count !== 16'd0) begin
      failures++;
      $display("FAIL mid_stall_reset: stall=%b ex=%h cnt=%0d required all zero", stall, dut_ex, hazard_count);
    end
    @(posedge clk);
    #3 reset = 0;
    model_reset();
    tick(os, es);
    checks++;
    if (os !== 1'b0 || dut_ex !== exp) begin
      failures++;
      $display("FAIL mid_stall_recover: stall=%b ex=%h required 0 %h", os, dut_ex, exp);
    end
  endtask

  task automatic test_saturation();
    logic os; bit es;
    int   target;
    int   budget = 0;
    target = exp_cnt + 36;
    load_instr(K_LW, 5'd8, 5'd8, 5'd0);
    while (exp_cnt < target && budget < 200) begin
      tick(os, es);
      budget++;
      checks++;
      if (s_count !== 5'(sat31(exp_cnt)) || hazard_count !== exp_cnt[15:0] ||
          small_ex !== exp || s_stall !== stall) begin
        failures++;
        $display("FAIL saturation_step: small=%0d wide=%0d required %0d %0d", s_count, hazard_count,
                 sat31(exp_cnt), exp_cnt);
      end
    end
    checks++;
    if (budget >= 200) begin failures++; $display("FAIL saturation_budget: events=%0d required %0d", exp_cnt, target); end
    checks++;
    if (s_count !== 5'h1f) begin failures++; $display("FAIL saturation_hold: got %h required 1f", s_count); end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load_use();
    test_zero_reg();
    test_flush_priority();
    test_random();
    test_reset_mid_stall();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
